// File: rtl/clockworks_pkg.sv
// rtl/clockworks_pkg.sv - shared types and helpers for the clockworks reset slice
package clockworks_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIRE = 2'd2
  } wdt_state_t;

  localparam int WDT_FIRE_CNT_W = 8;

  // Saturating increment for the fire counter: holds at all-ones.
  function automatic logic [WDT_FIRE_CNT_W-1:0] fire_cnt_inc(
    input logic [WDT_FIRE_CNT_W-1:0] c
  );
    if (c == {WDT_FIRE_CNT_W{1'b1}}) begin
      return c;
    end
    return c + WDT_FIRE_CNT_W'(1);
  endfunction

endpackage

// File: rtl/watchdog_reset.sv
// rtl/watchdog_reset.sv - heartbeat watchdog driving a timed active-low reset pulse
module watchdog_reset
  import clockworks_pkg::*;
#(
  parameter int TIMEOUT = 1000000,
  parameter int WARN    = 750000,
  parameter int PULSE   = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      kick,
  input  logic                      status_clr,
  output logic                      wdt_resetn,
  output logic                      warn,
  output logic                      expired,
  output logic [WDT_FIRE_CNT_W-1:0] fire_cnt
);

  // Count only ever reaches TIMEOUT-1, so this width never wraps.
  localparam int CNT_W   = $clog2(TIMEOUT + 1);
  localparam int PULSE_W = $clog2(PULSE + 1);

  localparam logic [CNT_W-1:0]   TERM_CNT  = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0]   WARN_CNT  = CNT_W'(WARN);
  localparam logic [PULSE_W-1:0] PULSE_END = PULSE_W'(PULSE);

  wdt_state_t         state;
  logic [CNT_W-1:0]   count;
  logic [PULSE_W-1:0] pulse_cnt;
  logic [CNT_W-1:0]   count_inc;

  assign count_inc = count + CNT_W'(1);

  // Watchdog FSM; every output is a register so wdt_resetn cannot glitch.
  // In FIRE, pulse_cnt steps 0..PULSE-1 with wdt_resetn low, and the cycle it
  // reaches PULSE releases the reset and drops back to IDLE (enable must re-arm).
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      count      <= '0;
      pulse_cnt  <= '0;
      wdt_resetn <= 1'b1;
      warn       <= 1'b0;
      expired    <= 1'b0;
      fire_cnt   <= '0;
    end else begin
      // A fire entry later in this block overrides the clear.
      if (status_clr) begin
        expired <= 1'b0;
      end

      case (state)
        IDLE: begin
          count      <= '0;
          warn       <= 1'b0;
          wdt_resetn <= 1'b1;
          if (enable) begin
            state <= RUN;
          end
        end

        RUN: begin
          if (!enable) begin
            state <= IDLE;
            count <= '0;
            warn  <= 1'b0;
          end else if (kick) begin
            count <= '0;
            warn  <= 1'b0;
          end else if (count == TERM_CNT) begin
            state     <= FIRE;
            count     <= '0;
            pulse_cnt <= '0;
            warn      <= 1'b0;
            expired   <= 1'b1;
            fire_cnt  <= fire_cnt_inc(fire_cnt);
          end else begin
            count <= count_inc;
            warn  <= (count_inc >= WARN_CNT);
          end
        end

        FIRE: begin
          if (pulse_cnt == PULSE_END) begin
            state      <= IDLE;
            pulse_cnt  <= '0;
            wdt_resetn <= 1'b1;
          end else begin
            pulse_cnt  <= pulse_cnt + PULSE_W'(1);
            wdt_resetn <= 1'b0;
          end
        end

        default: begin
          state      <= IDLE;
          wdt_resetn <= 1'b1;
          warn       <= 1'b0;
        end
      endcase
    end
  end

endmodule
